// File: rtl/uart_rx_if.sv
// uart_rx_if: byte-output handshake between the UART receive engine and its consumer.
//   rx_valid     : rx_data holds an unread byte (driven by the receiver)
//   rx_data      : received byte (driven by the receiver)
//   rx_ready     : consumer accepts the byte when rx_valid && rx_ready
//   rx_frame_err : one-cycle pulse, a stop bit was sampled low
//   rx_overrun   : one-cycle pulse, a completed byte was dropped
// Modports: master = receiver side, slave = consumer side.
interface uart_rx_if;
  logic       rx_valid;
  logic [7:0] rx_data;
  logic       rx_ready;
  logic       rx_frame_err;
  logic       rx_overrun;

  modport master (output rx_valid, output rx_data, output rx_frame_err,
                  output rx_overrun, input rx_ready);
  modport slave  (input rx_valid, input rx_data, input rx_frame_err,
                  input rx_overrun, output rx_ready);
endinterface

// File: rtl/uart_rx.sv
// uart_rx: 8N1/8N2 UART receive engine with a 16x oversampling baud counter
// that restarts on every detected start edge. Received bytes are presented
// on a valid/ready output register carried by uart_rx_if.
//
// Ports:
//   clk       : system clock
//   rst_n     : asynchronous active-low reset
//   cfg_div   : oversample divider, one sample tick every cfg_div+1 clocks
//   cfg_rxen  : receive enable; dropping it aborts a frame in progress
//   cfg_nstop : 0 = one stop bit, 1 = two stop bits
//   uart_rxd  : serial input, asynchronous, idle high
//   rx        : uart_rx_if.master (rx_valid, rx_data, rx_ready,
//               rx_frame_err, rx_overrun)
//
// Build option: define UART_RX_MAJORITY_EN to decide each bit by a
// majority vote of samples 6/8/10 (decision at sample 10). Without it the
// bit is the single sample 8 and all decisions are taken at sample 8.
module uart_rx (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] cfg_div,
  input  logic        cfg_rxen,
  input  logic        cfg_nstop,
  input  logic        uart_rxd,
  uart_rx_if.master   rx
);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t      state;
  logic        rxd_p0;
  logic        rxd_p1;
  logic        rxd_s;
  logic [15:0] div_cnt;
  logic [3:0]  smp_cnt;
  logic [2:0]  bit_cnt;
  logic        stop_cnt;
  logic [7:0]  shreg;
  logic        valid_q;
  logic [7:0]  data_q;
  logic        ferr_q;
  logic        ovr_q;
  logic        tick;
  logic        dec_tick;
  logic        end_tick;
  logic        start_det;
  logic        bit_val;

  // Stage p0/p1: two-flop synchronizer, idle-high reset value
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rxd_p0 <= 1'b1;
      rxd_p1 <= 1'b1;
    end else begin
      rxd_p0 <= uart_rxd;
      rxd_p1 <= rxd_p0;
    end
  end

  assign rxd_s = rxd_p1;

  // Baud counter: smp_cnt holds n-1 during the tick that is sample n
  assign tick      = (div_cnt == cfg_div);
  assign start_det = (state == IDLE) && cfg_rxen && !rxd_s;
  assign end_tick  = tick && (smp_cnt == 4'd15);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt <= '0;
      smp_cnt <= '0;
    end else if (start_det) begin
      div_cnt <= '0;
      smp_cnt <= '0;
    end else if (tick) begin
      div_cnt <= '0;
      smp_cnt <= smp_cnt + 4'd1;
    end else begin
      div_cnt <= div_cnt + 16'd1;
    end
  end

`ifdef UART_RX_MAJORITY_EN
  logic s6;
  logic s8;

  function automatic logic majority3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s6 <= 1'b1;
      s8 <= 1'b1;
    end else if (tick) begin
      if (smp_cnt == 4'd5) s6 <= rxd_s;
      if (smp_cnt == 4'd7) s8 <= rxd_s;
    end
  end

  assign dec_tick = tick && (smp_cnt == 4'd9);
  assign bit_val  = majority3(s6, s8, rxd_s);
`else
  assign dec_tick = tick && (smp_cnt == 4'd7);
  assign bit_val  = rxd_s;
`endif

  // Frame FSM with registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      bit_cnt  <= '0;
      stop_cnt <= 1'b0;
      shreg    <= '0;
      valid_q  <= 1'b0;
      data_q   <= '0;
      ferr_q   <= 1'b0;
      ovr_q    <= 1'b0;
    end else begin
      ferr_q <= 1'b0;
      ovr_q  <= 1'b0;
      // A delivery later in this block overrides the clear
      if (valid_q && rx.rx_ready) valid_q <= 1'b0;
      if (!cfg_rxen) begin
        state <= IDLE;
      end else begin
        case (state)
          IDLE: begin
            if (!rxd_s) state <= START;
          end
          START: begin
            if (dec_tick && bit_val) begin
              state <= IDLE;
            end else if (end_tick) begin
              state   <= DATA;
              bit_cnt <= '0;
            end
          end
          DATA: begin
            if (dec_tick) shreg <= {bit_val, shreg[7:1]};
            if (end_tick) begin
              bit_cnt <= bit_cnt + 3'd1;
              if (bit_cnt == 3'd7) begin
                state    <= STOP;
                stop_cnt <= 1'b0;
              end
            end
          end
          STOP: begin
            if (dec_tick) begin
              if (!bit_val) ferr_q <= 1'b1;
              // Leaving at mid-stop lets the next start edge be caught
              if (stop_cnt == cfg_nstop) begin
                state <= IDLE;
                if (!valid_q || rx.rx_ready) begin
                  data_q  <= shreg;
                  valid_q <= 1'b1;
                end else begin
                  ovr_q <= 1'b1;
                end
              end
            end else if (end_tick) begin
              stop_cnt <= stop_cnt + 1'b1;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  assign rx.rx_valid     = valid_q;
  assign rx.rx_data      = data_q;
  assign rx.rx_frame_err = ferr_q;
  assign rx.rx_overrun   = ovr_q;

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: self-checking bench for uart_rx. Frames are generated at the
// pin level from byte/config descriptions; expected bytes, error counts and
// delivery latency are derived from the frame format and oversampling rules.
module tb_uart_rx;

`ifdef UART_RX_MAJORITY_EN
  localparam int DEC = 10;
`else
  localparam int DEC = 8;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [15:0] cfg_div = 16'd0;
  logic        cfg_rxen = 1'b1;
  logic        cfg_nstop = 1'b0;
  logic        uart_rxd = 1'b1;
  logic        ready = 1'b1;

  uart_rx_if rxif();
  assign rxif.rx_ready = ready;

  uart_rx dut (
    .clk(clk),
    .rst_n(rst_n),
    .cfg_div(cfg_div),
    .cfg_rxen(cfg_rxen),
    .cfg_nstop(cfg_nstop),
    .uart_rxd(uart_rxd),
    .rx(rxif)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;
  int t_start = 0;
  int ferr_cnt = 0;
  int ovr_cnt = 0;
  logic [7:0] got_q[$];
  int         got_t[$];
  logic [7:0] exp_q[$];

  // Monitor: every cycle with valid && ready is one accepted byte
  always @(negedge clk) begin
    if (rst_n && rxif.rx_valid && ready) begin
      got_q.push_back(rxif.rx_data);
      got_t.push_back(cyc);
    end
    if (rxif.rx_frame_err) ferr_cnt++;
    if (rxif.rx_overrun) ovr_cnt++;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic set_cfg(input int div, input logic nstop);
    cfg_div   = div[15:0];
    cfg_nstop = nstop;
    step(2);
  endtask

  // Drive one frame; stop_low forces the first stop bit low, corrupt6
  // inverts a 3-clock window centred on sample 6 of every data bit.
  task automatic send_frame(input logic [7:0] d8, input int div, input logic nstop,
                            input logic stop_low, input logic corrupt6);
    int   nbits;
    int   per;
    int   c6;
    logic v;
    nbits   = nstop ? 11 : 10;
    per     = 16 * (div + 1);
    c6      = 6 * (div + 1);
    t_start = cyc;
    for (int b = 0; b < nbits; b++) begin
      if (b == 0) v = 1'b0;
      else if (b <= 8) v = d8[b-1];
      else v = !(stop_low && b == 9);
      for (int c = 0; c < per; c++) begin
        uart_rxd = v;
        if (corrupt6 && b >= 1 && b <= 8 && c >= c6 - 1 && c <= c6 + 1) uart_rxd = ~v;
        step(1);
      end
    end
    uart_rxd = 1'b1;
  endtask

  task automatic wait_got(input int n, input int budget);
    for (int i = 0; i < budget && got_q.size() < n; i++) step(1);
    checks++;
    if (got_q.size() < n) begin
      failures++;
      $display("FAIL wait_delivery got=%0d need=%0d", got_q.size(), n);
    end
  endtask

  task automatic clear_q();
    got_q.delete();
    got_t.delete();
    exp_q.delete();
  endtask

  task automatic test_reset();
    #1 rst_n = 1'b0;
    #1;
    checks++; if (rxif.rx_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", rxif.rx_valid); end
    checks++; if (rxif.rx_data !== 8'h00) begin failures++; $display("FAIL reset_data got=%h exp=00", rxif.rx_data); end
    checks++; if (rxif.rx_frame_err !== 1'b0) begin failures++; $display("FAIL reset_ferr got=%b exp=0", rxif.rx_frame_err); end
    checks++; if (rxif.rx_overrun !== 1'b0) begin failures++; $display("FAIL reset_ovr got=%b exp=0", rxif.rx_overrun); end
    step(3);
    rst_n = 1'b1;
    step(5);
  endtask

  task automatic test_basic();
    int f0, o0, c0, lat;
    ready = 1'b1;
    set_cfg(0, 1'b0);
    clear_q();
    f0 = ferr_cnt; o0 = ovr_cnt;
    send_frame(8'hA5, 0, 1'b0, 1'b0, 1'b0);
    c0 = t_start;
    wait_got(1, 200);
    lat = got_t.size() > 0 ? got_t[0] - c0 : -1;
    checks++; if (got_q.size() == 0 || got_q[0] !== 8'hA5) begin failures++; $display("FAIL basic_data got=%h exp=a5", got_q.size() > 0 ? got_q[0] : 8'hxx); end
    checks++; if (lat != 3 + (16 * 9 + DEC)) begin failures++; $display("FAIL basic_latency got=%0d exp=%0d", lat, 3 + 16 * 9 + DEC); end
    checks++; if (ferr_cnt != f0) begin failures++; $display("FAIL basic_ferr got=%0d exp=0", ferr_cnt - f0); end
    checks++; if (ovr_cnt != o0) begin failures++; $display("FAIL basic_ovr got=%0d exp=0", ovr_cnt - o0); end
  endtask

  task automatic test_back_to_back();
    int sp;
    ready = 1'b1;
    set_cfg(3, 1'b1);
    clear_q();
    send_frame(8'h3C, 3, 1'b1, 1'b0, 1'b0);
    send_frame(8'hC3, 3, 1'b1, 1'b0, 1'b0);
    wait_got(2, 400);
    sp = got_t.size() > 1 ? got_t[1] - got_t[0] : -1;
    checks++; if (got_q.size() < 1 || got_q[0] !== 8'h3C) begin failures++; $display("FAIL b2b_first got=%h exp=3c", got_q.size() > 0 ? got_q[0] : 8'hxx); end
    checks++; if (got_q.size() < 2 || got_q[1] !== 8'hC3) begin failures++; $display("FAIL b2b_second got=%h exp=c3", got_q.size() > 1 ? got_q[1] : 8'hxx); end
    checks++; if (sp != 11 * 64) begin failures++; $display("FAIL b2b_spacing got=%0d exp=%0d", sp, 11 * 64); end
  endtask

  task automatic test_glitch();
    int f0;
    ready = 1'b1;
    set_cfg(0, 1'b0);
    clear_q();
    f0 = ferr_cnt;
    uart_rxd = 1'b0;
    step(4);
    uart_rxd = 1'b1;
    step(40);
    checks++; if (got_q.size() != 0) begin failures++; $display("FAIL glitch_delivery got=%0d exp=0", got_q.size()); end
    checks++; if (rxif.rx_valid !== 1'b0) begin failures++; $display("FAIL glitch_valid got=%b exp=0", rxif.rx_valid); end
    checks++; if (ferr_cnt != f0) begin failures++; $display("FAIL glitch_ferr got=%0d exp=0", ferr_cnt - f0); end
    send_frame(8'h5A, 0, 1'b0, 1'b0, 1'b0);
    wait_got(1, 200);
    checks++; if (got_q.size() != 1 || got_q[0] !== 8'h5A) begin failures++; $display("FAIL glitch_recover got=%h exp=5a", got_q.size() > 0 ? got_q[0] : 8'hxx); end
  endtask

  task automatic test_frame_err();
    int f0;
    ready = 1'b1;
    set_cfg(1, 1'b1);
    clear_q();
    f0 = ferr_cnt;
    send_frame(8'h55, 1, 1'b1, 1'b1, 1'b0);
    step(100);
    checks++; if (ferr_cnt - f0 != 1) begin failures++; $display("FAIL ferr_pulses got=%0d exp=1", ferr_cnt - f0); end
    checks++; if (got_q.size() != 1) begin failures++; $display("FAIL ferr_count got=%0d exp=1", got_q.size()); end
    checks++; if (got_q.size() == 0 || got_q[0] !== 8'h55) begin failures++; $display("FAIL ferr_data got=%h exp=55", got_q.size() > 0 ? got_q[0] : 8'hxx); end
  endtask

  task automatic test_overrun();
    int o0;
    ready = 1'b0;
    set_cfg(1, 1'b0);
    clear_q();
    o0 = ovr_cnt;
    send_frame(8'h11, 1, 1'b0, 1'b0, 1'b0);
    send_frame(8'h22, 1, 1'b0, 1'b0, 1'b0);
    step(20);
    checks++; if (rxif.rx_valid !== 1'b1) begin failures++; $display("FAIL ovr_valid got=%b exp=1", rxif.rx_valid); end
    checks++; if (rxif.rx_data !== 8'h11) begin failures++; $display("FAIL ovr_data got=%h exp=11", rxif.rx_data); end
    checks++; if (ovr_cnt - o0 != 1) begin failures++; $display("FAIL ovr_pulses got=%0d exp=1", ovr_cnt - o0); end
    ready = 1'b1;
    step(2);
    checks++; if (rxif.rx_valid !== 1'b0) begin failures++; $display("FAIL ovr_clear got=%b exp=0", rxif.rx_valid); end
    checks++; if (got_q.size() != 1 || got_q[0] !== 8'h11) begin failures++; $display("FAIL ovr_accept got=%h exp=11", got_q.size() > 0 ? got_q[0] : 8'hxx); end
  endtask

  task automatic test_random();
    int f0, o0, div;
    logic nstop;
    logic [7:0] d;
    ready = 1'b1;
    clear_q();
    f0 = ferr_cnt; o0 = ovr_cnt;
    for (int k = 0; k < 6; k++) begin
      div   = $urandom_range(0, 3);
      nstop = 1'($urandom_range(0, 1));
      d     = 8'($urandom);
      set_cfg(div, nstop);
      exp_q.push_back(d);
      send_frame(d, div, nstop, 1'b0, 1'b0);
    end
    wait_got(6, 400);
    for (int k = 0; k < 6; k++) begin
      checks++;
      if (k >= got_q.size() || got_q[k] !== exp_q[k]) begin
        failures++;
        $display("FAIL random_byte%0d got=%h exp=%h", k, k < got_q.size() ? got_q[k] : 8'hxx, exp_q[k]);
      end
    end
    checks++; if (ferr_cnt != f0 || ovr_cnt != o0) begin failures++; $display("FAIL random_errs ferr=%0d ovr=%0d exp=0", ferr_cnt - f0, ovr_cnt - o0); end
  endtask

  task automatic test_rxen_abort();
    int f0;
    ready = 1'b1;
    set_cfg(0, 1'b0);
    clear_q();
    f0 = ferr_cnt;
    uart_rxd = 1'b0;
    step(60);
    cfg_rxen = 1'b0;
    step(3);
    uart_rxd = 1'b1;
    step(200);
    cfg_rxen = 1'b1;
    step(20);
    checks++; if (got_q.size() != 0 || ferr_cnt != f0) begin failures++; $display("FAIL rxen_abort deliveries=%0d ferr=%0d exp=0", got_q.size(), ferr_cnt - f0); end
  endtask

  task automatic test_majority();
`ifdef UART_RX_MAJORITY_EN
    ready = 1'b1;
    set_cfg(3, 1'b0);
    clear_q();
    send_frame(8'hF0, 3, 1'b0, 1'b0, 1'b1);
    wait_got(1, 300);
    checks++; if (got_q.size() != 1 || got_q[0] !== 8'hF0) begin failures++; $display("FAIL majority_data got=%h exp=f0", got_q.size() > 0 ? got_q[0] : 8'hxx); end
`endif
  endtask

  task automatic test_midframe_reset();
    ready = 1'b0;
    set_cfg(0, 1'b0);
    clear_q();
    send_frame(8'h77, 0, 1'b0, 1'b0, 1'b0);
    step(5);
    checks++; if (rxif.rx_valid !== 1'b1 || rxif.rx_data !== 8'h77) begin failures++; $display("FAIL mrst_pre valid=%b data=%h exp=1/77", rxif.rx_valid, rxif.rx_data); end
    uart_rxd = 1'b0;
    step(50);
    #2 rst_n = 1'b0;
    #1;
    checks++; if (rxif.rx_valid !== 1'b0) begin failures++; $display("FAIL mrst_valid got=%b exp=0", rxif.rx_valid); end
    checks++; if (rxif.rx_data !== 8'h00) begin failures++; $display("FAIL mrst_data got=%h exp=00", rxif.rx_data); end
    checks++; if (rxif.rx_frame_err !== 1'b0) begin failures++; $display("FAIL mrst_ferr got=%b exp=0", rxif.rx_frame_err); end
    checks++; if (rxif.rx_overrun !== 1'b0) begin failures++; $display("FAIL mrst_ovr got=%b exp=0", rxif.rx_overrun); end
    step(3);
    uart_rxd = 1'b1;
    step(2);
    rst_n = 1'b1;
    step(5);
    ready = 1'b1;
    clear_q();
    send_frame(8'h9C, 0, 1'b0, 1'b0, 1'b0);
    wait_got(1, 200);
    checks++; if (got_q.size() != 1 || got_q[0] !== 8'h9C) begin failures++; $display("FAIL mrst_after got=%h exp=9c", got_q.size() > 0 ? got_q[0] : 8'hxx); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_glitch();
    test_frame_err();
    test_overrun();
    test_random();
    test_rxen_abort();
    test_majority();
    test_midframe_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
# uart_rx

UART receive engine: recovers 8N1/8N2 serial frames from the `uart_rxd` pin and presents each received byte on a valid/ready output register. It sits beside the UART transmitter and shares its configuration (`cfg_div`, `cfg_nstop`). It has its own 16x oversampling baud counter, which restarts at every detected start edge.

## Interface
- No parameters.
- `clk` in 1: system clock.
- `rst_n` in 1: asynchronous active-low reset.
- `cfg_div` in 16: oversample divider; one sample tick every `cfg_div+1` clocks; 16 ticks per bit.
- `cfg_rxen` in 1: receive enable.
- `cfg_nstop` in 1: 0 = one stop bit, 1 = two stop bits.
- `uart_rxd` in 1: serial input, asynchronous to `clk`, idle high.
- `rx_valid` out 1: `rx_data` holds an unread byte.
- `rx_data` out 8: received byte.
- `rx_ready` in 1: consumer accepts the byte when `rx_valid && rx_ready`.
- `rx_frame_err` out 1: one-cycle pulse when a stop bit is sampled low.
- `rx_overrun` out 1: one-cycle pulse when a completed byte is dropped because the output register is occupied.

## Operation
- Input synchronizer: `uart_rxd` passes through 2 flops, both reset to 1. All logic uses the synchronized value `rxd_s`.
- Baud counter:
  - `div_cnt` counts 0..`cfg_div`. A tick occurs when `div_cnt == cfg_div`, after which `div_cnt` wraps to 0.
  - `smp_cnt` (4 bits) increments on each tick. Sample n is the tick that moves `smp_cnt` from n-1 to n (mod 16).
  - Both counters are cleared on start detection.
- Bit decision (with majority enabled): `bit = majority(rxd_s at samples 6, 8, 10)`. The decision is available at sample 10.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE: if `cfg_rxen && rxd_s == 0`, clear the counters and go to START.
  - START:
    - At sample 10: if the decided bit is 1 (false start), go to IDLE.
    - At sample 16: go to DATA with `bit_cnt = 0`.
  - DATA:
    - At sample 10: shift the decided bit into `shreg` from the MSB side (LSB first on the wire).
    - At sample 16: increment `bit_cnt`. On `bit_cnt == 7`, go to STOP with `stop_cnt = 0`.
  - STOP:
    - At sample 10, if the decided bit is 0, pulse `rx_frame_err`. The frame-error check is made on every stop bit; a frame whose stop bits are all high produces no pulse.
    - At sample 10 of the last stop bit (`stop_cnt == cfg_nstop`): deliver the byte and go to IDLE. Returning at mid-stop allows back-to-back frames.
    - Otherwise, at sample 16, increment `stop_cnt`.
- Delivery:
  - If `rx_valid == 0` or `rx_ready == 1` on the delivery cycle: `rx_data <= shreg` and `rx_valid <= 1`.
  - Otherwise, pulse `rx_overrun`. The new byte is dropped and the old `rx_data` is kept.
  - Bytes are delivered even when a frame error occurs.
- Output handshake: `rx_valid` clears in the cycle after `rx_valid && rx_ready`, unless a delivery happens in the same cycle, in which case it stays 1 with the new data.
- `cfg_rxen` deasserted mid-frame: the FSM returns to IDLE next cycle. No delivery, no error pulse. `rx_valid`/`rx_data` are untouched.

## Timing
- Reset values: `rx_valid = 0`, `rx_data = 8'h00`, `rx_frame_err = 0`, `rx_overrun = 0`, FSM = IDLE, all counters 0, shift register 0.
- Pin-to-FSM latency: 2 clocks (synchronizer) + 1 clock (IDLE detection).
- Bit period: `16*(cfg_div+1)` clocks.
- Delivery timing: `rx_valid` rises 1 clock after the sample-10 tick of the last stop bit.
- Reset asserted mid-frame: everything immediately takes its reset value. After release, the receiver waits in IDLE for a new low level.
- A `cfg_div` change takes effect at the next counter wrap. Changing it mid-frame is undefined.

## Configuration
- `UART_RX_MAJORITY_EN` defined: 3-sample majority vote (samples 6/8/10), decision at sample 10.
- `UART_RX_MAJORITY_EN` undefined: single sample at sample 8 is the bit value. All decision points (false start, data shift, stop check, delivery) move from sample 10 to sample 8.

## Test plan
- `cfg_div=0`, `cfg_nstop=0`, send 8'hA5 (16 clk/bit), `rx_ready` held 1 → `rx_valid` pulses, `rx_data=8'hA5`, no error pulses.
- `cfg_div=3`, `cfg_nstop=1`, send 8'h3C then 8'hC3 back-to-back, `rx_ready=1` → two deliveries, 8'h3C then 8'hC3, spaced 11*64 clocks apart.
- Low glitch of 4 clocks on `uart_rxd` (`cfg_div=0`) → FSM returns to IDLE at sample 10, no `rx_valid`.
- Send 8'h55 with the stop bit driven low → `rx_frame_err` pulses once, `rx_data=8'h55`, `rx_valid=1`.
- `rx_ready=0`, send 8'h11 then 8'h22 → `rx_data` stays 8'h11, `rx_overrun` pulses once at the second delivery.
- With `UART_RX_MAJORITY_EN` defined, corrupt only sample 6 of each data bit of 8'hF0 → `rx_data=8'hF0`. Also assert `rst_n` mid-frame → all outputs return to 0 asynchronously.
